imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: length header, then 32-bit words written to sequential IMEM addresses.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned IMEM_SIZE  = 256,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WE,
  output logic [31:0] W_Addr,
  output logic [31:0] W_Ins,
  output logic        Hold,
  output logic        Done,
  output logic        Err,
  output logic [31:0] WordCnt
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State after a complete payload: checksum byte if enabled, else done.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   len_q, len_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   word_cnt_d;
  logic [WORD_W-1:0]   addr_d, ins_d;
  logic                we_d, rdy_d, hold_d, done_d, err_d;
  logic                accept;
  logic [WORD_W-1:0]   len_next, shift_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      len_q      <= '0;
      shift_q    <= '0;
      WordCnt    <= '0;
      WE         <= 1'b0;
      W_Addr     <= '0;
      W_Ins      <= '0;
      RxReady    <= 1'b0;
      Hold       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      WordCnt    <= word_cnt_d;
      WE         <= we_d;
      W_Addr     <= addr_d;
      W_Ins      <= ins_d;
      RxReady    <= rdy_d;
      Hold       <= hold_d;
      Done       <= done_d;
      Err        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign accept     = RxValid && RxReady;
  // Header is always big-endian; data word order follows BIG_ENDIAN.
  assign len_next   = {len_q[WORD_W-BYTE_W-1:0], RxData};
  assign shift_next = BIG_ENDIAN ? {shift_q[WORD_W-BYTE_W-1:0], RxData}
                                 : {RxData, shift_q[WORD_W-1:BYTE_W]};

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    word_cnt_d = WordCnt;
    we_d       = 1'b0;
    addr_d     = W_Addr;
    ins_d      = W_Ins;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          len_d      = '0;
          shift_d    = '0;
          word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d      = len_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ RxData;
`endif
          if (byte_cnt_q == 2'd3) begin
            if (len_next == '0)                      state_d = S_FINISH;
            else if (len_next > WORD_W'(IMEM_SIZE))  state_d = S_ERR;
            else                                     state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d    = shift_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ RxData;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            ins_d      = shift_next;
            addr_d     = {WordCnt[WORD_W-3:0], 2'b00};
            word_cnt_d = WordCnt + WORD_W'(1);
            if (word_cnt_d == len_q) state_d = S_FINISH;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (RxData == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
             || (state_d == S_CSUM)
`endif
             ;
    hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: big- and little-endian instances share one byte stream.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;

  logic        be_rdy, be_we, be_hold, be_done, be_err;
  logic [31:0] be_addr, be_ins, be_wcnt;
  logic        le_rdy, le_we, le_hold, le_done, le_err;
  logic [31:0] le_addr, le_ins, le_wcnt;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] be_q[$];
  logic [63:0] le_q[$];
  logic [7:0]  csum_acc = 8'h00;
  bit          gaps = 1'b0;
  bit          watch_hold = 1'b0;
  int          hold_drops = 0;

  always #5 CLK = ~CLK;

  imem_loader #(.IMEM_SIZE(256), .BIG_ENDIAN(1'b1)) u_be (
    .CLK(CLK), .RST(RST), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(be_rdy), .WE(be_we), .W_Addr(be_addr), .W_Ins(be_ins),
    .Hold(be_hold), .Done(be_done), .Err(be_err), .WordCnt(be_wcnt)
  );

  imem_loader #(.IMEM_SIZE(256), .BIG_ENDIAN(1'b0)) u_le (
    .CLK(CLK), .RST(RST), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(le_rdy), .WE(le_we), .W_Addr(le_addr), .W_Ins(le_ins),
    .Hold(le_hold), .Done(le_done), .Err(le_err), .WordCnt(le_wcnt)
  );

  // Capture every write strobe as {addr, ins}.
  always @(negedge CLK) begin
    if (be_we === 1'b1) be_q.push_back({be_addr, be_ins});
    if (le_we === 1'b1) le_q.push_back({le_addr, le_ins});
    if (watch_hold && be_hold !== 1'b1) hold_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    be_q.delete();
    le_q.delete();
    csum_acc = 8'h00;
    @(negedge CLK); Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
  endtask

  // Presents a byte at a negedge; it is taken at the following posedge once RxReady is high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK); RxValid = 1'b0;
      end
    end
    @(negedge CLK); RxData = b; RxValid = 1'b1;
    while (be_rdy !== 1'b1 && n < 20) begin
      @(negedge CLK); n++;
    end
    check("rx_ready", 32'(be_rdy), 32'd1);
    csum_acc = csum_acc ^ b;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic end_stream();
    @(negedge CLK); RxValid = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic finish_load();
    logic [7:0] c;
    c = csum_acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(c);
`endif
    watch_hold = 1'b0;
    end_stream();
  endtask

  initial begin
    logic [63:0] e;

    // Reset for two cycles.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy", 32'(be_rdy), 32'd0);
    check("rst_we", 32'(be_we), 32'd0);
    check("rst_addr", be_addr, 32'd0);
    check("rst_ins", be_ins, 32'd0);
    check("rst_hold", 32'(be_hold), 32'd0);
    check("rst_done", 32'(be_done), 32'd0);
    check("rst_err", 32'(be_err), 32'd0);
    check("rst_wcnt", be_wcnt, 32'd0);
    check("rst_le_rdy", 32'(le_rdy), 32'd0);
    RST = 1'b0;

    // Valid bytes without Start are ignored.
    RxData = 8'hAA; RxValid = 1'b1;
    repeat (4) @(negedge CLK);
    RxValid = 1'b0;
    check("idle_we_count", 32'(be_q.size()), 32'd0);
    check("idle_rdy", 32'(be_rdy), 32'd0);
    check("idle_hold", 32'(be_hold), 32'd0);

    // Single big-endian word, back to back.
    do_start();
    check("start_hold", 32'(be_hold), 32'd1);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    finish_load();
    check("w1_count", 32'(be_q.size()), 32'd1);
    e = (be_q.size() > 0) ? be_q[0] : 64'hx;
    check("w1_addr", e[63:32], 32'h0);
    check("w1_ins", e[31:0], 32'h1234_5678);
    check("w1_done", 32'(be_done), 32'd1);
    check("w1_hold", 32'(be_hold), 32'd0);
    check("w1_wcnt", be_wcnt, 32'd1);
    check("w1_rdy", 32'(be_rdy), 32'd0);
    check("w1_le_ins", le_ins, 32'h7856_3412);

    // Three words with random gaps; Hold stays high until Done.
    gaps = 1'b1;
    hold_drops = 0;
    do_start();
    watch_hold = 1'b1;
    send_word(32'd3);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0102_0304);
    send_word(32'hA5A5_5A5A);
    finish_load();
    gaps = 1'b0;
    check("w3_count", 32'(be_q.size()), 32'd3);
    e = (be_q.size() > 0) ? be_q[0] : 64'hx;
    check("w3_a0", e[63:32], 32'h0);
    check("w3_i0", e[31:0], 32'hDEAD_BEEF);
    e = (be_q.size() > 1) ? be_q[1] : 64'hx;
    check("w3_a1", e[63:32], 32'h4);
    check("w3_i1", e[31:0], 32'h0102_0304);
    e = (be_q.size() > 2) ? be_q[2] : 64'hx;
    check("w3_a2", e[63:32], 32'h8);
    check("w3_i2", e[31:0], 32'hA5A5_5A5A);
    check("w3_hold_drops", 32'(hold_drops), 32'd0);
    check("w3_done", 32'(be_done), 32'd1);
    check("w3_wcnt", be_wcnt, 32'd3);
    check("w3_hold_held", be_ins, 32'hA5A5_5A5A);

    // Little-endian assembly.
    do_start();
    send_word(32'h0000_0001);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    finish_load();
    check("le_count", 32'(le_q.size()), 32'd1);
    e = (le_q.size() > 0) ? le_q[0] : 64'hx;
    check("le_addr", e[63:32], 32'h0);
    check("le_ins", e[31:0], 32'h1234_5678);
    check("le_done", 32'(le_done), 32'd1);

    // Oversize header (257) is rejected, then a valid load recovers.
    do_start();
    send_word(32'h0000_0101);
    end_stream();
    check("ovr_err", 32'(be_err), 32'd1);
    check("ovr_hold", 32'(be_hold), 32'd1);
    check("ovr_done", 32'(be_done), 32'd0);
    check("ovr_rdy", 32'(be_rdy), 32'd0);
    check("ovr_we_count", 32'(be_q.size()), 32'd0);
    check("ovr_le_err", 32'(le_err), 32'd1);
    do_start();
    check("restart_err_clr", 32'(be_err), 32'd0);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    finish_load();
    check("restart_err", 32'(be_err), 32'd0);
    check("restart_done", 32'(be_done), 32'd1);
    check("restart_count", 32'(be_q.size()), 32'd1);

    // Zero-length load completes without writes.
    do_start();
    send_word(32'h0000_0000);
    finish_load();
    check("n0_done", 32'(be_done), 32'd1);
    check("n0_count", 32'(be_q.size()), 32'd0);
    check("n0_wcnt", be_wcnt, 32'd0);

    // Full-size load (N = IMEM_SIZE) reaches the last address.
    do_start();
    send_word(32'h0000_0100);
    for (int i = 0; i < 256; i++) send_word(32'h0A00_0000 | 32'(i));
    finish_load();
    check("max_count", 32'(be_q.size()), 32'd256);
    e = (be_q.size() > 0) ? be_q[be_q.size()-1] : 64'hx;
    check("max_last_addr", e[63:32], 32'h0000_03FC);
    check("max_last_ins", e[31:0], 32'h0A00_00FF);
    check("max_done", 32'(be_done), 32'd1);
    check("max_wcnt", be_wcnt, 32'h100);

    // Reset after two data bytes discards the partial word.
    do_start();
    send_word(32'h0000_0001);
    send_byte(8'h12); send_byte(8'h34);
    @(negedge CLK); RxValid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_count", 32'(be_q.size()), 32'd0);
    check("mid_rst_rdy", 32'(be_rdy), 32'd0);
    check("mid_rst_hold", 32'(be_hold), 32'd0);
    check("mid_rst_wcnt", be_wcnt, 32'd0);
    check("mid_rst_ins", be_ins, 32'd0);
    check("mid_rst_addr", be_addr, 32'd0);
    check("mid_rst_done", 32'(be_done), 32'd0);
    check("mid_rst_err", 32'(be_err), 32'd0);
    RST = 1'b0;
    do_start();
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    finish_load();
    check("post_rst_count", 32'(be_q.size()), 32'd1);
    check("post_rst_ins", be_ins, 32'hCAFE_F00D);
    check("post_rst_done", 32'(be_done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Explicit checksum bytes: 0x09 matches, 0x00 does not.
    do_start();
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    send_byte(8'h09);
    end_stream();
    check("cs_ok_done", 32'(be_done), 32'd1);
    check("cs_ok_err", 32'(be_err), 32'd0);
    do_start();
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    send_byte(8'h00);
    end_stream();
    check("cs_bad_err", 32'(be_err), 32'd1);
    check("cs_bad_done", 32'(be_done), 32'd0);
    check("cs_bad_hold", 32'(be_hold), 32'd1);
    check("cs_bad_count", 32'(be_q.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
